// File: rtl/ldr_sink.sv
// ldr_sink: packs loader byte writes into 16-bit big-endian RAM words.
// Optional running byte checksum on ldr_sum when LDR_CHKSUM_EN is defined.
module ldr_sink (
  input  logic        sysclk,
  input  logic        rstn,
  input  logic [19:0] ldr_addr,
  input  logic [7:0]  ldr_wdat,
  input  logic        ldr_aen,
  input  logic        ldr_wr,
  output logic        ldr_ack,
  output logic [18:0] mem_addr,
  output logic [15:0] mem_wdat,
  output logic [1:0]  mem_be,
  output logic        mem_wr,
  input  logic        mem_ack,
  output logic        busy
`ifdef LDR_CHKSUM_EN
  ,
  output logic [15:0] ldr_sum
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    MEMWR,
    ACK,
    REL
  } state_t;

  state_t      state_q, state_d;
  logic        pend_v_q, pend_v_d;
  logic [7:0]  pend_dat_q, pend_dat_d;
  logic [18:0] pend_waddr_q, pend_waddr_d;
  logic        ack_after_q, ack_after_d;
  logic [18:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdat_q, mem_wdat_d;
  logic [1:0]  mem_be_q, mem_be_d;

  logic        is_idle;
  logic        req;
  logic        odd;
  logic [18:0] waddr;
  logic        pair;
  logic        flush;
  logic        latch;
  logic        single;
  logic        accept;

  assign is_idle = (state_q == IDLE);
  assign req     = ldr_aen & ldr_wr;
  assign odd     = ldr_addr[0];
  assign waddr   = ldr_addr[19:1];
  assign pair    = req & odd & pend_v_q
                 & (pend_waddr_q == waddr);
  // A pending even byte that cannot pair is written alone first.
  assign flush   = pend_v_q
                 & (~ldr_aen | (ldr_wr & ~pair));
  assign latch   = req & ~odd & ~pend_v_q;
  assign single  = req & odd & ~pend_v_q;
  assign accept  = is_idle & (pair | latch | single);

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      pend_v_q     <= 1'b0;
      pend_dat_q   <= 8'h00;
      pend_waddr_q <= 19'd0;
      ack_after_q  <= 1'b0;
      mem_addr_q   <= 19'd0;
      mem_wdat_q   <= 16'h0000;
      mem_be_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      pend_v_q     <= pend_v_d;
      pend_dat_q   <= pend_dat_d;
      pend_waddr_q <= pend_waddr_d;
      ack_after_q  <= ack_after_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdat_q   <= mem_wdat_d;
      mem_be_q     <= mem_be_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_v_d     = pend_v_q;
    pend_dat_d   = pend_dat_q;
    pend_waddr_d = pend_waddr_q;
    ack_after_d  = ack_after_q;
    mem_addr_d   = mem_addr_q;
    mem_wdat_d   = mem_wdat_q;
    mem_be_d     = mem_be_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          pair: begin
            mem_addr_d  = waddr;
            mem_wdat_d  = {pend_dat_q, ldr_wdat};
            mem_be_d    = 2'b11;
            pend_v_d    = 1'b0;
            ack_after_d = 1'b1;
            state_d     = MEMWR;
          end
          flush: begin
            mem_addr_d  = pend_waddr_q;
            mem_wdat_d  = {pend_dat_q, 8'h00};
            mem_be_d    = 2'b10;
            pend_v_d    = 1'b0;
            ack_after_d = 1'b0;
            state_d     = MEMWR;
          end
          latch: begin
            pend_v_d     = 1'b1;
            pend_dat_d   = ldr_wdat;
            pend_waddr_d = waddr;
            state_d      = ACK;
          end
          single: begin
            mem_addr_d  = waddr;
            mem_wdat_d  = {8'h00, ldr_wdat};
            mem_be_d    = 2'b01;
            ack_after_d = 1'b1;
            state_d     = MEMWR;
          end
          default: state_d = IDLE;
        endcase
      end
      MEMWR: begin
        if (mem_ack) begin
          state_d = ack_after_q ? ACK : IDLE;
        end
      end
      ACK: state_d = REL;
      REL: begin
        if (!ldr_wr) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ldr_ack  = (state_q == ACK);
  assign mem_wr   = (state_q == MEMWR);
  assign mem_addr = mem_addr_q;
  assign mem_wdat = mem_wdat_q;
  assign mem_be   = mem_be_q;
  assign busy     = ~is_idle | pend_v_q;

`ifdef LDR_CHKSUM_EN
  logic [7:0]  acc_q;
  logic        aen_q;
  logic [15:0] sum_q;

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= 8'h00;
      aen_q <= 1'b0;
      sum_q <= 16'h0000;
    end else begin
      aen_q <= ldr_aen;
      if (accept) begin
        acc_q <= ldr_wdat;
      end
      if (ldr_aen & ~aen_q) begin
        sum_q <= 16'h0000;
      end else if (state_q == ACK) begin
        sum_q <= sum_q + {8'h00, acc_q};
      end
    end
  end

  assign ldr_sum = sum_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_ldr_sink.sv
// tb_ldr_sink: directed plus randomized loader traffic against a
// byte-pairing reference model of the expected RAM writes.
module tb_ldr_sink;

  logic        sysclk = 1'b0;
  logic        rstn = 1'b0;
  logic [19:0] ldr_addr = '0;
  logic [7:0]  ldr_wdat = '0;
  logic        ldr_aen = 1'b0;
  logic        ldr_wr = 1'b0;
  logic        ldr_ack;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdat;
  logic [1:0]  mem_be;
  logic        mem_wr;
  logic        mem_ack = 1'b0;
  logic        busy;
`ifdef LDR_CHKSUM_EN
  logic [15:0] ldr_sum;
`endif

  ldr_sink dut (
    .sysclk   (sysclk),
    .rstn     (rstn),
    .ldr_addr (ldr_addr),
    .ldr_wdat (ldr_wdat),
    .ldr_aen  (ldr_aen),
    .ldr_wr   (ldr_wr),
    .ldr_ack  (ldr_ack),
    .mem_addr (mem_addr),
    .mem_wdat (mem_wdat),
    .mem_be   (mem_be),
    .mem_wr   (mem_wr),
    .mem_ack  (mem_ack),
    .busy     (busy)
`ifdef LDR_CHKSUM_EN
    ,
    .ldr_sum  (ldr_sum)
`endif
  );

  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic [18:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } wr_t;

  wr_t exp_q[$];
  wr_t got_q[$];
  wr_t cur;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int ack_cyc = 0;
  int memack_cyc = 0;
  int mem_delay = 0;
  int wr_cnt = 0;

  bit          m_pv = 0;
  logic [7:0]  m_pd = '0;
  logic [18:0] m_pa = '0;
  logic [15:0] m_sum = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected RAM traffic for one accepted byte, from the pairing rules.
  task automatic model_byte(input logic [19:0] a, input logic [7:0] d);
    wr_t w;
    if (m_pv && !(a[0] && m_pa == a[19:1])) begin
      w = '{m_pa, {m_pd, 8'h00}, 2'b10};
      exp_q.push_back(w);
      m_pv = 0;
    end
    if (!a[0]) begin
      m_pv = 1;
      m_pd = d;
      m_pa = a[19:1];
    end else if (m_pv) begin
      w = '{a[19:1], {m_pd, d}, 2'b11};
      exp_q.push_back(w);
      m_pv = 0;
    end else begin
      w = '{a[19:1], {8'h00, d}, 2'b01};
      exp_q.push_back(w);
    end
    m_sum = m_sum + 16'(d);
  endtask

  task automatic model_end();
    wr_t w;
    if (m_pv) begin
      w = '{m_pa, {m_pd, 8'h00}, 2'b10};
      exp_q.push_back(w);
      m_pv = 0;
    end
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, "_wr"}, 64'(got_q[i]), 64'(exp_q[i]));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // One clock: behaves as the RAM arbiter and counts loader acks.
  task automatic tick();
    bit prev;
    @(posedge sysclk);
    #1;
    cyc++;
    prev = mem_ack;
    mem_ack = 1'b0;
    if (ldr_ack) begin
      ack_cnt++;
      ack_cyc = cyc;
    end
    if (mem_wr && !prev) begin
      if (wr_cnt == 0) begin
        cur = '{mem_addr, mem_wdat, mem_be};
        got_q.push_back(cur);
      end else begin
        chk("mem_stable", 64'({mem_addr, mem_wdat, mem_be}),
            64'(cur));
      end
      if (wr_cnt >= mem_delay) begin
        mem_ack = 1'b1;
        memack_cyc = cyc;
        wr_cnt = 0;
      end else begin
        wr_cnt++;
      end
    end
  endtask

  task automatic send_byte(input logic [19:0] a, input logic [7:0] d,
                           input int hold, output int lat);
    int a0;
    int c0;
    int n;
    a0 = ack_cnt;
    ldr_addr = a;
    ldr_wdat = d;
    ldr_wr = 1'b1;
    c0 = cyc;
    n = 0;
    while (ack_cnt == a0 && n < 100) begin
      tick();
      n++;
    end
    chk("ack_seen", 64'(ack_cnt > a0), 64'd1);
    lat = ack_cyc - c0;
    for (int i = 0; i < hold; i++) tick();
    ldr_wr = 1'b0;
    tick();
    tick();
    chk("one_ack", 64'(ack_cnt), 64'(a0 + 1));
  endtask

  task automatic start_session();
    ldr_aen = 1'b1;
    m_sum = '0;
    tick();
  endtask

  task automatic end_session(input string tag);
    int n;
    ldr_aen = 1'b0;
    n = 0;
    tick();
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_busy0"}, 64'(busy), 64'd0);
    model_end();
    cmp_writes(tag);
  endtask

  int lat;
  int a_snap;
  logic [18:0] wbase;
  logic [19:0] ra;
  logic [7:0]  rd;
  int n;

  initial begin
    repeat (2) tick();
    chk("rst_ack", 64'(ldr_ack), 64'd0);
    chk("rst_memwr", 64'(mem_wr), 64'd0);
    chk("rst_be", 64'(mem_be), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdat", 64'(mem_wdat), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
`ifdef LDR_CHKSUM_EN
    chk("rst_sum", 64'(ldr_sum), 64'd0);
`endif
    rstn = 1'b1;
    tick();
    start_session();

    mem_delay = 1;
    model_byte(20'h00000, 8'h12);
    send_byte(20'h00000, 8'h12, 0, lat);
    chk("even_lat", 64'(lat), 64'd1);
    chk("even_nowr", 64'(got_q.size()), 64'd0);
    model_byte(20'h00001, 8'h34);
    send_byte(20'h00001, 8'h34, 0, lat);
    chk("odd_lat", 64'(ack_cyc), 64'(memack_cyc + 1));
    cmp_writes("pair");

    mem_delay = 3;
    model_byte(20'h00005, 8'hAB);
    send_byte(20'h00005, 8'hAB, 1, lat);
    chk("single_lat", 64'(ack_cyc), 64'(memack_cyc + 1));
    cmp_writes("single");

    mem_delay = 0;
    model_byte(20'h00010, 8'h56);
    send_byte(20'h00010, 8'h56, 0, lat);
    model_byte(20'h00020, 8'h78);
    send_byte(20'h00020, 8'h78, 0, lat);
    cmp_writes("flush_other");
    chk("pend_busy", 64'(busy), 64'd1);
    end_session("flush_78");

    start_session();
    model_byte(20'h00002, 8'h9A);
    send_byte(20'h00002, 8'h9A, 0, lat);
    end_session("flush_aen");

    a_snap = ack_cnt;
    mem_ack = 1'b1;
    tick();
    tick();
    chk("stray_memwr", 64'(mem_wr), 64'd0);
    chk("stray_busy", 64'(busy), 64'd0);
    chk("stray_ack", 64'(ack_cnt), 64'(a_snap));

`ifdef LDR_CHKSUM_EN
    start_session();
    chk("sum_clr", 64'(ldr_sum), 64'd0);
    model_byte(20'h00100, 8'hFF);
    send_byte(20'h00100, 8'hFF, 0, lat);
    model_byte(20'h00101, 8'h02);
    send_byte(20'h00101, 8'h02, 0, lat);
    chk("sum_val", 64'(ldr_sum), 64'h0101);
    end_session("sum");
    start_session();
    tick();
    chk("sum_new", 64'(ldr_sum), 64'd0);
    end_session("sum2");
`endif

    start_session();
    mem_delay = 2;
    model_byte(20'h00031, 8'hC3);
    send_byte(20'h00031, 8'hC3, 10, lat);
    cmp_writes("held");

    model_byte(20'h00040, 8'h11);
    send_byte(20'h00040, 8'h11, 0, lat);
    mem_delay = 1000;
    ldr_addr = 20'h00061;
    ldr_wdat = 8'h22;
    ldr_wr = 1'b1;
    n = 0;
    while (!mem_wr && n < 10) begin
      tick();
      n++;
    end
    chk("rst_inwr", 64'(mem_wr), 64'd1);
    a_snap = ack_cnt;
    rstn = 1'b0;
    #1;
    chk("arst_memwr", 64'(mem_wr), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ack", 64'(ldr_ack), 64'd0);
    chk("arst_be", 64'(mem_be), 64'd0);
    ldr_wr = 1'b0;
    ldr_aen = 1'b0;
    got_q.delete();
    exp_q.delete();
    m_pv = 0;
    wr_cnt = 0;
    mem_delay = 0;
    tick();
    rstn = 1'b1;
    tick();
    mem_ack = 1'b1;
    repeat (3) tick();
    chk("late_ack", 64'(ack_cnt), 64'(a_snap));
    chk("late_memwr", 64'(mem_wr), 64'd0);
    chk("rst_nopend", 64'(busy), 64'd0);
    end_session("noflush");

    start_session();
    for (int it = 0; it < 60; it++) begin
      wbase = 19'($urandom_range(0, 3)) + 19'h00200;
      ra = {wbase, 1'b0};
      ra[0] = 1'($urandom_range(0, 1));
      rd = 8'($urandom);
      mem_delay = $urandom_range(0, 3);
      model_byte(ra, rd);
      send_byte(ra, rd, $urandom_range(0, 2), lat);
      if (ra[0]) begin
        chk("rnd_lat", 64'(ack_cyc), 64'(memack_cyc + 1));
      end
      cmp_writes("rnd");
      chk("rnd_busy", 64'(busy), 64'(m_pv));
`ifdef LDR_CHKSUM_EN
      chk("rnd_sum", 64'(ldr_sum), 64'(m_sum));
`endif
      if (it % 15 == 14) begin
        end_session("rnd_end");
        start_session();
      end
    end
    end_session("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
